// File: rtl/fft_loader_pkg.sv
// Shared FFT definitions: transform size, sample width, complex RAM word and loader states.
// Imported by the loader, its address sub-module and the bus interface.
package fft_loader_pkg;

    localparam int FFT_LOG2N = 9;
    localparam int FFT_N     = 1 << FFT_LOG2N;
    localparam int SAMPLE_W  = 16;

    // RAM word layout: real part in the upper half, imaginary part in the lower half
    typedef struct packed {
        logic signed [SAMPLE_W-1:0] re;
        logic signed [SAMPLE_W-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FLUSH = 2'd1,
        FULL  = 2'd2
    } loader_state_t;

    // Promote a real time-domain sample to a complex RAM word with zero imaginary part
    function automatic cplx_t real_to_cplx(input logic signed [SAMPLE_W-1:0] s);
        cplx_t c;
        c.re = s;
        c.im = '0;
        return c;
    endfunction

endpackage

// File: rtl/fft_loader_if.sv
// Sample stream, FFT-core handshake and RAM write port of the FFT input loader.
// master = loader side, slave = environment (upstream source, FFT core, RAM).
interface fft_loader_if
    import fft_loader_pkg::*;
#(
    parameter int N = FFT_LOG2N,
    parameter int W = SAMPLE_W
) ();

    logic                sample_valid;
    logic signed [W-1:0] sample_in;
    logic                sample_ready;
    logic                fft_ack;
    logic                frame_ready;
    logic                ram_we;
    logic [N-1:0]        ram_waddr;
    logic [2*W-1:0]      ram_wdata;
    logic [N-1:0]        sample_idx;

    modport master (
        input  sample_valid,
        input  sample_in,
        input  fft_ack,
        output sample_ready,
        output frame_ready,
        output ram_we,
        output ram_waddr,
        output ram_wdata,
        output sample_idx
    );

    modport slave (
        output sample_valid,
        output sample_in,
        output fft_ack,
        input  sample_ready,
        input  frame_ready,
        input  ram_we,
        input  ram_waddr,
        input  ram_wdata,
        input  sample_idx
    );

endinterface

// File: rtl/bitrev.sv
// Combinational N-bit bit reversal: dout[i] = din[N-1-i].
// Zero latency, no flow control.
module bitrev #(
    parameter int N = 9
) (
    input  logic [N-1:0] din,
    output logic [N-1:0] dout
);

    for (genvar i = 0; i < N; i++) begin : g_rev
        assign dout[i] = din[N-1-i];
    end

endmodule

// File: rtl/fft_loader_addr.sv
// Write-address generator: bit-reverses the natural sample index and registers it.
// One cycle latency from index to address; updates only when en is high, otherwise holds.
module fft_loader_addr #(
    parameter int N = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] idx,
    output logic [N-1:0] waddr
);

    logic [N-1:0] idx_rev;

    bitrev #(.N(N)) u_bitrev (
        .din  (idx),
        .dout (idx_rev)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waddr <= '0;
        end else if (en) begin
            waddr <= idx_rev;
        end
    end

endmodule

// File: rtl/fft_loader.sv
// FFT input loader: writes a 2^N real-sample frame into RAM in bit-reversed order, 1-cycle write latency.
// Accepts 1 sample/cycle while loading; sample_ready is low from the last write until fft_ack frees the RAM.
module fft_loader
    import fft_loader_pkg::*;
#(
    parameter int N = FFT_LOG2N,
    parameter int W = SAMPLE_W
) (
    input  logic        clk,
    input  logic        reset,
    fft_loader_if.master bus
);

    loader_state_t   state;
    loader_state_t   state_nxt;
    logic            ready;
    logic            full;
    logic            handshake;
    logic            last_sample;
    logic [N-1:0]    idx;
    logic            we_q;
    logic [2*W-1:0]  wdata_q;
    logic [N-1:0]    waddr;

    assign handshake   = bus.sample_valid && ready;
    assign last_sample = &idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // FLUSH gives the final RAM write one cycle to commit before the frame is advertised
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        full      = 1'b0;
        case (state)
            LOAD: begin
                ready = 1'b1;
                if (bus.sample_valid && last_sample) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                state_nxt = FULL;
            end
            FULL: begin
                full = 1'b1;
                if (bus.fft_ack) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    // Index wraps to 0 naturally after 2^N-1, ready for the next frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (handshake) begin
            idx <= idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            we_q <= handshake;
            if (handshake) begin
                wdata_q <= {bus.sample_in, {W{1'b0}}};
            end
        end
    end

    fft_loader_addr #(.N(N)) u_addr (
        .clk   (clk),
        .reset (reset),
        .en    (handshake),
        .idx   (idx),
        .waddr (waddr)
    );

    assign bus.sample_ready = ready;
    assign bus.frame_ready  = full;
    assign bus.ram_we       = we_q;
    assign bus.ram_waddr    = waddr;
    assign bus.ram_wdata    = wdata_q;
    assign bus.sample_idx   = idx;

endmodule
